// File: rtl/edge_det_pkg.sv
// edge_det_pkg
//   Shared types for the debounced edge detector.
//   state_e : per-channel debounce FSM states (LOW / CHK_HI / HIGH / CHK_LO)
//   mode_e  : per-channel reporting mode (off / rise / fall / both)
//   mode_select() : applies a 2-bit mode to a rise/fall pulse pair
package edge_det_pkg;

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    CHK_HI = 2'd1,
    HIGH   = 2'd2,
    CHK_LO = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  // Bit 0 of the mode enables rising edges, bit 1 enables falling edges.
  function automatic logic mode_select(input logic [1:0] m, input logic rise, input logic fall);
    return (rise & m[0]) | (fall & m[1]);
  endfunction

endpackage

// File: rtl/edge_det_chan.sv
// edge_det_chan
//   One channel: SYNC_STAGES-deep synchroniser followed by a debounce FSM.
//   An edge is accepted once the synced sample has held its new value for
//   DEBOUNCE+1 consecutive samples; shorter excursions are dropped silently.
// Ports
//   clk, reset    : rising-edge clock, async active-high reset
//   level         : raw asynchronous input level
//   p_edge        : registered 1-cycle pulse on an accepted rising edge
//   n_edge        : registered 1-cycle pulse on an accepted falling edge
//   level_stable  : debounced level (high in HIGH and CHK_LO)
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic p_edge,
  output logic n_edge,
  output logic level_stable
);

  localparam int CW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_e                 state, state_next;
  logic [CW-1:0]          cnt, cnt_next;
  logic                   p_next, n_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], level};
  end

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= LOW;
      cnt    <= '0;
      p_edge <= 1'b0;
      n_edge <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      p_edge <= p_next;
      n_edge <= n_next;
    end
  end

  // cnt counts samples already seen at the new value; the edge is accepted
  // on the sample after cnt reaches DEBOUNCE. With DEBOUNCE=0 the check
  // states are skipped entirely.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    p_next     = 1'b0;
    n_next     = 1'b0;
    case (state)
      LOW: begin
        if (s) begin
          if (DEBOUNCE == 0) begin
            state_next = HIGH;
            p_next     = 1'b1;
          end else begin
            state_next = CHK_HI;
            cnt_next   = CW'(1);
          end
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_next = LOW;
        end else if (cnt == CNT_MAX) begin
          state_next = HIGH;
          p_next     = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      HIGH: begin
        if (!s) begin
          if (DEBOUNCE == 0) begin
            state_next = LOW;
            n_next     = 1'b1;
          end else begin
            state_next = CHK_LO;
            cnt_next   = CW'(1);
          end
        end
      end
      CHK_LO: begin
        if (s) begin
          state_next = HIGH;
        end else if (cnt == CNT_MAX) begin
          state_next = LOW;
          n_next     = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = LOW;
    endcase
  end

  assign level_stable = (state == HIGH) || (state == CHK_LO);

endmodule

// File: rtl/debounced_edge_detector.sv
// debounced_edge_detector
//   Multi-channel debounced edge detector with per-channel mode masking,
//   sticky pending flags and a combined interrupt.
//   Optional feature macro: EDGE_COUNT_EN adds the CNT_W parameter and the
//   edge_cnt port with one saturating edge counter per channel.
// Ports
//   clk, reset    : rising-edge clock, async active-high reset
//   level         : raw asynchronous levels, one per channel
//   mode          : 2 bits per channel, 00 off / 01 rise / 10 fall / 11 both
//   clr           : per-channel clear strobe for pending (and counter)
//   p_edge/n_edge : unmasked accepted rising / falling pulses
//   any_edge      : pulses allowed through by mode
//   level_stable  : debounced levels
//   pending       : sticky flags set by any_edge
//   irq           : OR of all pending flags
//   edge_cnt      : CNT_W-bit counter per channel (EDGE_COUNT_EN only)
module debounced_edge_detector
  import edge_det_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
`ifdef EDGE_COUNT_EN
  , parameter int CNT_W     = 8
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   level,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clr,
  output logic [CHANNELS-1:0]   p_edge,
  output logic [CHANNELS-1:0]   n_edge,
  output logic [CHANNELS-1:0]   any_edge,
  output logic [CHANNELS-1:0]   level_stable,
  output logic [CHANNELS-1:0]   pending,
  output logic                  irq
`ifdef EDGE_COUNT_EN
  , output logic [CHANNELS*CNT_W-1:0] edge_cnt
`endif
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .level       (level[i]),
      .p_edge      (p_edge[i]),
      .n_edge      (n_edge[i]),
      .level_stable(level_stable[i])
    );

    // Mode only filters what is reported; the channel FSM keeps running.
    assign any_edge[i] = mode_select(mode[2*i +: 2], p_edge[i], n_edge[i]);

`ifdef EDGE_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    // A clear coinciding with an edge restarts the count at one.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                          cnt_q <= '0;
      else if (clr[i])                    cnt_q <= any_edge[i] ? CNT_W'(1) : '0;
      else if (any_edge[i] && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign edge_cnt[i*CNT_W +: CNT_W] = cnt_q;
`endif
  end

  // A new edge takes priority over a clear arriving in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= any_edge | (pending & ~clr);
  end

  assign irq = |pending;

endmodule

// File: tb/tb_debounced_edge_detector.sv
// tb_debounced_edge_detector
//   Directed bench for debounced_edge_detector (CHANNELS=4, SYNC_STAGES=2,
//   DEBOUNCE=4). With EDGE_COUNT_EN defined the DUT is built with CNT_W=2
//   and the saturating counters are exercised as well.
module tb_debounced_edge_detector;

  logic       clk;
  logic       reset;
  logic [3:0] level;
  logic [7:0] mode;
  logic [3:0] clr;
  logic [3:0] p_edge, n_edge, any_edge, level_stable, pending;
  logic       irq;
`ifdef EDGE_COUNT_EN
  logic [7:0] edge_cnt;
`endif

  int checks = 0;
  int errors = 0;

`ifdef EDGE_COUNT_EN
  debounced_edge_detector #(
    .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE(4), .CNT_W(2)
  ) dut (
    .clk(clk), .reset(reset), .level(level), .mode(mode), .clr(clr),
    .p_edge(p_edge), .n_edge(n_edge), .any_edge(any_edge),
    .level_stable(level_stable), .pending(pending), .irq(irq),
    .edge_cnt(edge_cnt)
  );
`else
  debounced_edge_detector #(
    .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE(4)
  ) dut (
    .clk(clk), .reset(reset), .level(level), .mode(mode), .clr(clr),
    .p_edge(p_edge), .n_edge(n_edge), .any_edge(any_edge),
    .level_stable(level_stable), .pending(pending), .irq(irq)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One-cycle clear strobe on the channels in mask.
  task automatic applyStimulus(input logic [3:0] mask);
    clr = mask;
    tick();
    clr = 4'b0000;
  endtask

  // Runs n cycles, counting pulses and debounced-high cycles on one channel.
  task automatic countRun(input int ch, input int n, output int pc, output int nc,
                          output int ac, output int sc);
    pc = 0; nc = 0; ac = 0; sc = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      pc += int'(p_edge[ch]);
      nc += int'(n_edge[ch]);
      ac += int'(any_edge[ch]);
      sc += int'(level_stable[ch]);
    end
  endtask

  initial begin
    int pc, nc, ac, sc;
    int glitch_len[3];
    glitch_len = '{3, 4, 5};

    reset = 1'b1;
    level = 4'b0000;
    mode  = 8'h00;
    clr   = 4'b0000;
    repeat (3) tick();

    checkOutput("reset_p_edge",   32'(p_edge),       32'h0);
    checkOutput("reset_n_edge",   32'(n_edge),       32'h0);
    checkOutput("reset_any_edge", 32'(any_edge),     32'h0);
    checkOutput("reset_stable",   32'(level_stable), 32'h0);
    checkOutput("reset_pending",  32'(pending),      32'h0);
    checkOutput("reset_irq",      32'(irq),          32'h0);
`ifdef EDGE_COUNT_EN
    checkOutput("reset_edge_cnt", 32'(edge_cnt),     32'h0);
`endif

    mode  = 8'h55;
    reset = 1'b0;
    repeat (3) tick();

    // Clean rise on ch0: pulse in the cycle after the 7th edge.
    level[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("rise0_early_p", 32'(p_edge[0]), 32'h0);
    end
    checkOutput("rise0_chk_stable", 32'(level_stable[0]), 32'h0);
    tick();
    checkOutput("rise0_p_edge",   32'(p_edge[0]),       32'h1);
    checkOutput("rise0_any_edge", 32'(any_edge[0]),     32'h1);
    checkOutput("rise0_stable",   32'(level_stable[0]), 32'h1);
    tick();
    checkOutput("rise0_p_after",  32'(p_edge[0]),  32'h0);
    checkOutput("rise0_pending",  32'(pending),    32'h1);
    checkOutput("rise0_irq",      32'(irq),        32'h1);

    applyStimulus(4'b0001);
    checkOutput("clr0_pending", 32'(pending), 32'h0);
    checkOutput("clr0_irq",     32'(irq),     32'h0);

    // Fall on ch0 with rise-only mode: n_edge pulses but nothing is reported.
    level[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("fall0_early_n", 32'(n_edge[0]), 32'h0);
    end
    tick();
    checkOutput("fall0_n_edge",   32'(n_edge[0]),       32'h1);
    checkOutput("fall0_any_edge", 32'(any_edge[0]),     32'h0);
    checkOutput("fall0_stable",   32'(level_stable[0]), 32'h0);
    tick();
    checkOutput("fall0_pending",  32'(pending),         32'h0);

    // Glitches on ch1: 3 and 4 synced samples are dropped, 5 is accepted.
    for (int g = 0; g < 3; g++) begin
      level[1] = 1'b1;
      repeat (glitch_len[g]) tick();
      level[1] = 1'b0;
      countRun(1, 16, pc, nc, ac, sc);
      if (glitch_len[g] <= 4) begin
        checkOutput($sformatf("glitch%0d_p", glitch_len[g]),      32'(pc), 32'h0);
        checkOutput($sformatf("glitch%0d_n", glitch_len[g]),      32'(nc), 32'h0);
        checkOutput($sformatf("glitch%0d_stable", glitch_len[g]), 32'(sc), 32'h0);
        checkOutput($sformatf("glitch%0d_pending", glitch_len[g]), 32'(pending[1]), 32'h0);
      end else begin
        checkOutput("pulse5_p",       32'(pc),         32'h1);
        checkOutput("pulse5_n",       32'(nc),         32'h1);
        checkOutput("pulse5_pending", 32'(pending[1]), 32'h1);
      end
    end
    applyStimulus(4'b0010);

    // Masking on ch2: both edges pulse, only the rise sets pending.
    level[2] = 1'b1;
    countRun(2, 10, pc, nc, ac, sc);
    checkOutput("mask2_rise_p",   32'(pc),         32'h1);
    checkOutput("mask2_rise_any", 32'(ac),         32'h1);
    checkOutput("mask2_rise_pnd", 32'(pending[2]), 32'h1);
    applyStimulus(4'b0100);
    level[2] = 1'b0;
    countRun(2, 10, pc, nc, ac, sc);
    checkOutput("mask2_fall_n",   32'(nc),         32'h1);
    checkOutput("mask2_fall_any", 32'(ac),         32'h0);
    checkOutput("mask2_fall_pnd", 32'(pending[2]), 32'h0);

    // Set-vs-clear on ch3.
    level[3] = 1'b1;
    repeat (7) tick();
    checkOutput("setclr3_any", 32'(any_edge[3]), 32'h1);
    applyStimulus(4'b1000);
    checkOutput("setclr3_pending_kept", 32'(pending[3]), 32'h1);
    applyStimulus(4'b1000);
    checkOutput("setclr3_pending_clr", 32'(pending[3]), 32'h0);
    checkOutput("setclr3_irq",         32'(irq),        32'h0);

    // Reset while ch0 is in CHK_HI; ch3 is still high.
    level[0] = 1'b1;
    repeat (3) tick();
    checkOutput("rst_mid_chk_stable", 32'(level_stable[0]), 32'h0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_stable",  32'(level_stable), 32'h0);
    checkOutput("rst_mid_p_edge",  32'(p_edge),       32'h0);
    checkOutput("rst_mid_pending", 32'(pending),      32'h0);
    checkOutput("rst_mid_irq",     32'(irq),          32'h0);
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("rst_rel_early_p", 32'(p_edge), 32'h0);
    end
    tick();
    checkOutput("rst_rel_p_edge",   32'(p_edge),   32'h9);
    checkOutput("rst_rel_any_edge", 32'(any_edge), 32'h9);
    tick();
    checkOutput("rst_rel_p_after",  32'(p_edge),   32'h0);
    checkOutput("rst_rel_pending",  32'(pending),  32'h9);

    // All channels rising together.
    applyStimulus(4'b1111);
    level = 4'b0000;
    repeat (10) tick();
    level = 4'b1111;
    repeat (7) tick();
    checkOutput("all_p_edge",   32'(p_edge),   32'hF);
    checkOutput("all_any_edge", 32'(any_edge), 32'hF);
    tick();
    checkOutput("all_pending",  32'(pending),  32'hF);

`ifdef EDGE_COUNT_EN
    // Saturating 2-bit counters, both edges counted on ch0.
    mode = 8'hFF;
    applyStimulus(4'b1111);
    checkOutput("cnt_cleared", 32'(edge_cnt), 32'h0);
    for (int t = 1; t <= 5; t++) begin
      level[0] = ~level[0];
      repeat (10) tick();
      if (t == 2) checkOutput("cnt_two", 32'(edge_cnt[1:0]), 32'h2);
    end
    checkOutput("cnt_saturated", 32'(edge_cnt[1:0]), 32'h3);
    checkOutput("cnt_others",    32'(edge_cnt[7:2]), 32'h0);
    applyStimulus(4'b0001);
    checkOutput("cnt_clr", 32'(edge_cnt[1:0]), 32'h0);
    level[0] = ~level[0];
    repeat (7) tick();
    checkOutput("cnt_clr_edge_any", 32'(any_edge[0]), 32'h1);
    applyStimulus(4'b0001);
    checkOutput("cnt_clr_with_edge", 32'(edge_cnt[1:0]), 32'h1);
`else
    $display("[TB] counter feature not built, edge_cnt checks skipped");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
